// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: stage-status inputs from the datapath and the
// stall/flush/bubble controls plus statistics returned by the controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      IF_ID_instrout;
  logic             ID_EX_memread;
  logic [4:0]       ID_EX_rt;
  logic             EX_MEM_PCSrc;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             pipe_en;
  logic             id_ex_bubble;
  logic             flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output IF_ID_instrout, ID_EX_memread, ID_EX_rt, EX_MEM_PCSrc, mem_busy,
    input  pc_write, if_id_write, pipe_en, id_ex_bubble, flush,
           stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  IF_ID_instrout, ID_EX_memread, ID_EX_rt, EX_MEM_PCSrc, mem_busy,
    output pc_write, if_id_write, pipe_en, id_ex_bubble, flush,
           stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use bubble, branch flush, memory freeze
// with a held flush, saturating stall/flush counters and a sticky memory timeout.
//
// state    | meaning
// RUN      | memory ready, pipeline advancing normally
// MEM_WAIT | data memory busy, all stages frozen; taken branches held in r_pend_flush
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int BCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_pend_flush, w_pend_nxt;
  logic [BCW-1:0]   r_busy_cnt, w_busy_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             r_mem_timeout;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt;
  logic       w_uses_rt, w_lu, w_freeze, w_flush, w_lu_stall;
  logic       w_unused_instr;

  assign w_op  = hz.IF_ID_instrout[31:26];
  assign w_rs  = hz.IF_ID_instrout[25:21];
  assign w_rt  = hz.IF_ID_instrout[20:16];
  assign w_unused_instr = ^hz.IF_ID_instrout[15:0];

  // lw names rt as its destination, so only R-type, beq and sw read it.
  assign w_uses_rt = (w_op == 6'b000000) | (w_op == 6'b000100) | (w_op == 6'b101011);
  assign w_lu = hz.ID_EX_memread & (hz.ID_EX_rt != 5'd0) &
                ((hz.ID_EX_rt == w_rs) | ((hz.ID_EX_rt == w_rt) & w_uses_rt));

  assign w_freeze   = hz.mem_busy;
  assign w_flush    = ~hz.mem_busy & (hz.EX_MEM_PCSrc | r_pend_flush);
  assign w_lu_stall = ~hz.mem_busy & ~w_flush & w_lu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_pend_flush  <= 1'b0;
      r_busy_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_flush <= w_pend_nxt;
      r_busy_cnt   <= w_busy_nxt;
      if ((w_freeze | w_lu_stall) && r_stall_cnt != {CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && r_flush_cnt != {CNT_W{1'b1}})
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_busy_nxt == BCW'(MEM_TIMEOUT))
        r_mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (hz.mem_busy)  w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (!hz.mem_busy) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
    w_pend_nxt = hz.mem_busy ? (r_pend_flush | hz.EX_MEM_PCSrc) : 1'b0;
    if (!hz.mem_busy)
      w_busy_nxt = '0;
    else if (r_busy_cnt == BCW'(MEM_TIMEOUT))
      w_busy_nxt = r_busy_cnt;
    else
      w_busy_nxt = r_busy_cnt + BCW'(1);
  end

  always_comb begin
    hz.pc_write     = 1'b0;
    hz.if_id_write  = 1'b0;
    hz.pipe_en      = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.flush        = 1'b0;
    if (rst_n && !w_freeze) begin
      if (w_flush) begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.pipe_en     = 1'b1;
        hz.flush       = 1'b1;
      end else if (w_lu_stall) begin
        hz.pipe_en      = 1'b1;
        hz.id_ex_bubble = 1'b1;
      end else begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.pipe_en     = 1'b1;
      end
    end
  end

  assign hz.stall_count = r_stall_cnt;
  assign hz.flush_count = r_flush_cnt;
  assign hz.mem_timeout = r_mem_timeout;

endmodule
